// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus request/response types used by the arbiter and its clients.
package cbus_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [2:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W/8-1:0] strobe;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;
endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of i_valid at or after i_rr_ptr, wrapping.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_rr_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_index
);
  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_rot;
  logic [IW:0]    w_off;
  logic [IW:0]    w_sum;

  // Rotating a doubled vector puts the requester at rr_ptr in bit 0.
  assign w_dbl   = {i_valid, i_valid};
  assign w_rot   = w_dbl >> i_rr_ptr;
  assign o_found = |i_valid;

  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--)
      if (w_rot[k]) w_off = (IW+1)'(k);
  end

  assign w_sum   = {1'b0, i_rr_ptr} + w_off;
  assign o_index = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
endmodule

// File: rtl/cbus_arbiter.sv
// Burst-locked round-robin arbiter from NUM_REQ cache requesters onto one memory-side cache bus.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  cbus_req_t  [NUM_REQ-1:0]    ireqs,
  output cbus_resp_t [NUM_REQ-1:0]    iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp,
  output logic                        busy,
  output logic [GW-1:0]               grant
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t              r_state, w_state_nxt;
  logic [GW-1:0]       r_grant, w_grant_nxt;
  logic [GW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_REQ-1:0]  w_valid;
  logic                w_found;
  logic [GW-1:0]       w_pick;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) w_valid[i] = ireqs[i].valid;
  end

  rr_picker #(.N(NUM_REQ), .IW(GW)) u_pick (
    .i_valid  (w_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_index  (w_pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // oreq depends only on state, grant and ireqs, so oresp never reaches it combinationally.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    oreq         = '0;
    iresps       = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_grant_nxt = w_pick;
        end
      end
      BUSY: begin
        oreq            = ireqs[r_grant];
        iresps[r_grant] = oresp;
        if (oresp.ready && oresp.last) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy  = (r_state == BUSY);
  assign grant = r_grant;
endmodule
